batch_reverser: RTL

- Upstream stage of the backward recursion path in the control-bounded batch filter.
- Collects control-signal samples (N bits per sample) in fixed-length batches using two ping-pong banks.
- Emits each completed batch in time-reversed order, at the input rate, with batch-boundary markers.
- The downstream LUT + RecursionModule chain uses the markers to run its backward recursion one batch at a time.

---
 rtl/batch_reverser_pkg.sv | 7 +
 rtl/batch_bank_ram.sv | 38 +++
 rtl/batch_reverser.sv | 112 +++++++++++
 3 files changed

// File: rtl/batch_reverser_pkg.sv
// Shared types for the backward-recursion path of the batch filter.
// ctrl_t is the control-signal sample exchanged between reverser, LUT and Batch_top.
package batch_reverser_pkg;

  typedef logic [2:0] ctrl_t;

endpackage

// File: rtl/batch_bank_ram.sv
// DEPTH x N simple dual-port RAM: one write port, one registered read port.
// The read register clears on reset and holds its value while re_i is low.
module batch_bank_ram #(
  parameter int N     = 3,
  parameter int DEPTH = 64,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];
  logic [N-1:0] rdata_q;

  // Storage is deliberately not reset; contents are never read before being written.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/batch_reverser.sv
// Ping-pong batch store that replays each completed batch time-reversed at the input rate.
// One output per accepted input, one cycle later; no backpressure, downstream must always accept.
module batch_reverser
  import batch_reverser_pkg::*;
#(
  parameter int N     = 3,
  parameter int DEPTH = 64
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] in,
  input  logic         in_valid,
  output logic [N-1:0] out,
  output logic         out_valid,
  output logic         out_first,
  output logic         out_last
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          wr_bank_q, wr_bank_d;
  logic          primed_q,  primed_d;
  logic          rd_bank_q, rd_bank_d;
  logic          valid_q,   valid_d;
  logic          first_q,   first_d;
  logic          last_q,    last_d;

  logic [AW-1:0] rd_addr;
  logic [N-1:0]  rdata0, rdata1;
  logic          we0, we1, re0, re1;

  assign rd_addr = LAST_ADDR - wr_addr_q;

  always_comb begin
    wr_addr_d = wr_addr_q;
    wr_bank_d = wr_bank_q;
    primed_d  = primed_q;
    rd_bank_d = rd_bank_q;
    valid_d   = 1'b0;
    first_d   = 1'b0;
    last_d    = 1'b0;
    if (in_valid) begin
      valid_d   = primed_q;
      first_d   = primed_q && (wr_addr_q == '0);
      last_d    = primed_q && (wr_addr_q == LAST_ADDR);
      rd_bank_d = ~wr_bank_q;
      if (wr_addr_q == LAST_ADDR) begin
        wr_addr_d = '0;
        wr_bank_d = ~wr_bank_q;
        primed_d  = 1'b1;
      end else begin
        wr_addr_d = wr_addr_q + AW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_addr_q <= '0;
      wr_bank_q <= 1'b0;
      primed_q  <= 1'b0;
      rd_bank_q <= 1'b0;
      valid_q   <= 1'b0;
      first_q   <= 1'b0;
      last_q    <= 1'b0;
    end else begin
      wr_addr_q <= wr_addr_d;
      wr_bank_q <= wr_bank_d;
      primed_q  <= primed_d;
      rd_bank_q <= rd_bank_d;
      valid_q   <= valid_d;
      first_q   <= first_d;
      last_q    <= last_d;
    end
  end

  // Reads are gated by primed so out stays 0 instead of exposing unwritten storage.
  assign we0 = in_valid & ~wr_bank_q;
  assign we1 = in_valid &  wr_bank_q;
  assign re0 = in_valid &  wr_bank_q & primed_q;
  assign re1 = in_valid & ~wr_bank_q & primed_q;

  batch_bank_ram #(.N(N), .DEPTH(DEPTH)) u_bank0 (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we0),
    .waddr_i (wr_addr_q),
    .wdata_i (in),
    .re_i    (re0),
    .raddr_i (rd_addr),
    .rdata_o (rdata0)
  );

  batch_bank_ram #(.N(N), .DEPTH(DEPTH)) u_bank1 (
    .clk_i   (clk),
    .rst_i   (rst),
    .we_i    (we1),
    .waddr_i (wr_addr_q),
    .wdata_i (in),
    .re_i    (re1),
    .raddr_i (rd_addr),
    .rdata_o (rdata1)
  );

  assign out       = rd_bank_q ? rdata1 : rdata0;
  assign out_valid = valid_q;
  assign out_first = first_q;
  assign out_last  = last_q;

endmodule
